// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - BCD time types, digit limits and 24h/12h helpers for rtc_timekeeper
package rtc_pkg;

   typedef struct packed {
      logic [3:0] tens;
      logic [3:0] ones;
   } bcd2_t;

   localparam logic [3:0] MAX_SEC_T = 4'd5;
   localparam logic [3:0] MAX_MIN_T = 4'd5;
   localparam bcd2_t      MAX_HR    = 8'h23;

   function automatic bcd2_t bcd_inc_wrap(bcd2_t v, bcd2_t max);
      bcd2_t r;
      if (v == max) begin
         r = '0;
      end else if (v.ones == 4'd9) begin
         r.tens = v.tens + 4'd1;
         r.ones = 4'd0;
      end else begin
         r.tens = v.tens;
         r.ones = v.ones + 4'd1;
      end
      return r;
   endfunction

   // 00 -> 12 AM, 12 -> 12 PM, 13..23 -> 01..11 PM
   function automatic bcd2_t to_12h(bcd2_t h, output logic pm);
      logic [4:0] bin;
      logic [4:0] b12;
      bcd2_t      r;
      bin = 5'(h.tens) * 5'd10 + 5'(h.ones);
      pm  = (bin >= 5'd12);
      b12 = pm ? bin - 5'd12 : bin;
      if (b12 == 5'd0)
         b12 = 5'd12;
      if (b12 >= 5'd10)
         r = {4'd1, 4'(b12 - 5'd10)};
      else
         r = {4'd0, b12[3:0]};
      return r;
   endfunction

endpackage

// File: rtl/rtc_timekeeper_btn_sync_edge.sv
// rtl/rtc_timekeeper_btn_sync_edge.sv - 2-FF synchroniser plus falling-edge press pulse for an active-low button
module btn_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic btn_n,
   output logic press
);

   logic s1, s2, prev;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1   <= 1'b1;
         s2   <= 1'b1;
         prev <= 1'b1;
      end else begin
         s1   <= btn_n;
         s2   <= s1;
         prev <= s2;
      end
   end

   assign press = prev & ~s2;

endmodule

// File: rtl/rtc_timekeeper.sv
// rtl/rtc_timekeeper.sv - BCD HH:MM:SS time-of-day core with button set and 12h/24h display
// Optional alarm enabled by defining RTC_ALARM_EN.
module rtc_timekeeper
   import rtc_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 50_000_000,
   parameter int unsigned CNT_W      = 26,
   parameter int unsigned ALARM_SECS = 30
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       run,
   input  logic       mode12,
   input  logic       set_min_n,
   input  logic       set_hr_n,
   input  logic       alm_sel,
   output logic [7:0] sec_o,
   output logic [7:0] min_o,
   output logic [7:0] hr_o,
   output logic       pm_o,
   output logic       tick_o,
   output logic       alarm_o
);

   localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CLK_HZ - 1);
   localparam bcd2_t SEC_MAX = {MAX_SEC_T, 4'd9};
   localparam bcd2_t MIN_MAX = {MAX_MIN_T, 4'd9};

   logic [CNT_W-1:0] cnt;
   bcd2_t cur_sec, cur_min, cur_hr;
   bcd2_t sec_nx, min_nx, hr_nx, disp_hr;
   logic  disp_pm, min_press, hr_press, wrap, edit_alm, set_min, set_hr;

   btn_sync_edge u_min_btn (.clk(CLOCK_50), .reset(reset), .btn_n(set_min_n), .press(min_press));
   btn_sync_edge u_hr_btn  (.clk(CLOCK_50), .reset(reset), .btn_n(set_hr_n),  .press(hr_press));

   assign wrap    = run && (cnt == CNT_TOP);
   assign set_min = min_press && !run && !edit_alm;
   assign set_hr  = hr_press  && !run && !edit_alm;

   always_comb begin
      sec_nx = bcd_inc_wrap(cur_sec, SEC_MAX);
      min_nx = cur_min;
      hr_nx  = cur_hr;
      if (cur_sec == SEC_MAX) begin
         min_nx = bcd_inc_wrap(cur_min, MIN_MAX);
         if (cur_min == MIN_MAX)
            hr_nx = bcd_inc_wrap(cur_hr, MAX_HR);
      end
      disp_hr = to_12h(cur_hr, disp_pm);
      if (!mode12) begin
         disp_hr = cur_hr;
         disp_pm = 1'b0;
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         cnt     <= '0;
         cur_sec <= '0;
         cur_min <= '0;
         cur_hr  <= '0;
         tick_o  <= 1'b0;
         hr_o    <= mode12 ? 8'h12 : 8'h00;
         pm_o    <= 1'b0;
      end else begin
         tick_o <= wrap;
         hr_o   <= disp_hr;
         pm_o   <= disp_pm;
         if (run) begin
            cnt <= wrap ? '0 : cnt + CNT_W'(1);
            if (wrap) begin
               cur_sec <= sec_nx;
               cur_min <= min_nx;
               cur_hr  <= hr_nx;
            end
         end else begin
            // minute set restarts the current second so the new minute begins cleanly
            if (set_min) begin
               cur_min <= bcd_inc_wrap(cur_min, MIN_MAX);
               cur_sec <= '0;
               cnt     <= '0;
            end
            if (set_hr)
               cur_hr <= bcd_inc_wrap(cur_hr, MAX_HR);
         end
      end
   end

   assign sec_o = cur_sec;
   assign min_o = cur_min;

`ifdef RTC_ALARM_EN
   localparam int unsigned AW = $clog2(ALARM_SECS + 1);

   bcd2_t         alm_hr, alm_min;
   logic [AW-1:0] alm_left;
   logic          alm_q, alm_hit;

   assign edit_alm = alm_sel;
   assign alm_hit  = wrap && (sec_nx == '0) && (min_nx == alm_min) && (hr_nx == alm_hr);

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         alm_hr   <= '0;
         alm_min  <= '0;
         alm_left <= '0;
         alm_q    <= 1'b0;
      end else begin
         if (!run && alm_sel) begin
            if (min_press) alm_min <= bcd_inc_wrap(alm_min, MIN_MAX);
            if (hr_press)  alm_hr  <= bcd_inc_wrap(alm_hr, MAX_HR);
         end
         // any press silences the alarm, whatever run is
         if (min_press || hr_press) begin
            alm_q    <= 1'b0;
            alm_left <= '0;
         end else if (alm_hit) begin
            alm_q    <= 1'b1;
            alm_left <= AW'(ALARM_SECS);
         end else if (wrap && alm_q) begin
            if (alm_left <= AW'(1)) begin
               alm_q    <= 1'b0;
               alm_left <= '0;
            end else begin
               alm_left <= alm_left - AW'(1);
            end
         end
      end
   end

   assign alarm_o = alm_q;
`else
   logic unused_alarm;
   assign unused_alarm = &{1'b0, alm_sel, (ALARM_SECS != 0)};
   assign edit_alm     = 1'b0;
   assign alarm_o      = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_timekeeper.sv
// tb/tb_rtc_timekeeper.sv - self-checking bench for rtc_timekeeper (CLK_HZ=4, CNT_W=2, ALARM_SECS=2)
// Covers the alarm path only when RTC_ALARM_EN is defined.
module tb_rtc_timekeeper;

   localparam int CLK_HZ     = 4;
   localparam int CNT_W      = 2;
   localparam int ALARM_SECS = 2;

   logic       clk = 1'b0;
   logic       reset, run, mode12, set_min_n, set_hr_n, alm_sel;
   logic [7:0] sec_o, min_o, hr_o;
   logic       pm_o, tick_o, alarm_o;

   int n_tests = 0;
   int n_fail  = 0;
   int cur_hr  = 0;

   typedef struct {
      string      name;
      logic [7:0] sec, mins, hr;
      logic       pm, tick, alarm;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      int         hr;
      logic       m12;
      logic [7:0] exp_hr;
      logic       exp_pm;
   } vec_t;
   vec_t vecs[8];

   always #5 clk = ~clk;

   rtc_timekeeper #(.CLK_HZ(CLK_HZ), .CNT_W(CNT_W), .ALARM_SECS(ALARM_SECS)) dut (
      .CLOCK_50(clk), .reset(reset), .run(run), .mode12(mode12),
      .set_min_n(set_min_n), .set_hr_n(set_hr_n), .alm_sel(alm_sel),
      .sec_o(sec_o), .min_o(min_o), .hr_o(hr_o), .pm_o(pm_o),
      .tick_o(tick_o), .alarm_o(alarm_o)
   );

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input string name, input logic [7:0] s, input logic [7:0] m,
                       input logic [7:0] h, input logic p, input logic t, input logic a);
      exp_t e;
      e.name = name; e.sec = s; e.mins = m; e.hr = h; e.pm = p; e.tick = t; e.alarm = a;
      sb.push_back(e);
   endtask

   task automatic check_sb();
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         n_tests++;
         if ({sec_o, min_o, hr_o, pm_o, tick_o, alarm_o} !== {e.sec, e.mins, e.hr, e.pm, e.tick, e.alarm}) begin
            n_fail++;
            $display("FAIL %s: got sec=%h min=%h hr=%h pm=%b tick=%b alarm=%b, want sec=%h min=%h hr=%h pm=%b tick=%b alarm=%b",
                     e.name, sec_o, min_o, hr_o, pm_o, tick_o, alarm_o,
                     e.sec, e.mins, e.hr, e.pm, e.tick, e.alarm);
         end
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(1);
      reset = 1'b0;
   endtask

   task automatic press(input logic do_min, input logic do_hr);
      if (do_min) set_min_n = 1'b0;
      if (do_hr)  set_hr_n  = 1'b0;
      step(4);
      set_min_n = 1'b1;
      set_hr_n  = 1'b1;
      step(4);
   endtask

   task automatic press_n(input logic do_min, input int n);
      for (int i = 0; i < n; i++)
         press(do_min, !do_min);
   endtask

   initial begin
      reset = 1'b1; run = 1'b1; mode12 = 1'b0;
      set_min_n = 1'b1; set_hr_n = 1'b1; alm_sel = 1'b0;
      vecs[0] = '{0,  1'b1, 8'h12, 1'b0};
      vecs[1] = '{1,  1'b1, 8'h01, 1'b0};
      vecs[2] = '{11, 1'b1, 8'h11, 1'b0};
      vecs[3] = '{12, 1'b1, 8'h12, 1'b1};
      vecs[4] = '{13, 1'b1, 8'h01, 1'b1};
      vecs[5] = '{23, 1'b1, 8'h11, 1'b1};
      vecs[6] = '{13, 1'b0, 8'h13, 1'b0};
      vecs[7] = '{20, 1'b1, 8'h08, 1'b1};

      // free-running ticks from reset
      do_reset();
      push("reset", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      check_sb();
      for (int c = 1; c <= 12; c++) begin
         step(1);
         push($sformatf("run_c%0d", c), 8'(c / 4), 8'h00, 8'h00, 1'b0, (c % 4) == 0, 1'b0);
         check_sb();
      end

      // midnight rollover from 23:59:58
      run = 1'b0;
      do_reset();
      press_n(1'b0, 23);
      press_n(1'b1, 59);
      run = 1'b1;
      push("pre_235958", 8'h58, 8'h59, 8'h23, 1'b0, 1'b1, 1'b0);
      step(58 * 4);
      check_sb();
      push("at_235959", 8'h59, 8'h59, 8'h23, 1'b0, 1'b1, 1'b0);
      step(4);
      check_sb();
      push("rollover", 8'h00, 8'h00, 8'h23, 1'b0, 1'b1, 1'b0);
      step(4);
      check_sb();
      push("rollover_hr", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      step(1);
      check_sb();

      // minute set clears seconds and prescaler; presses while running are dropped
      run = 1'b0;
      do_reset();
      press_n(1'b0, 5);
      press_n(1'b1, 59);
      run = 1'b1;
      step(29);
      run = 1'b0;
      push("pre_min_set", 8'h07, 8'h59, 8'h05, 1'b0, 1'b0, 1'b0);
      step(1);
      check_sb();
      push("min_set_wrap", 8'h00, 8'h00, 8'h05, 1'b0, 1'b0, 1'b0);
      press(1'b1, 1'b0);
      check_sb();
      run = 1'b1;
      push("presc_cleared", 8'h00, 8'h00, 8'h05, 1'b0, 1'b0, 1'b0);
      step(3);
      check_sb();
      push("first_tick_after_set", 8'h01, 8'h00, 8'h05, 1'b0, 1'b1, 1'b0);
      step(1);
      check_sb();
      push("press_while_run", 8'h03, 8'h00, 8'h05, 1'b0, 1'b1, 1'b0);
      press(1'b1, 1'b0);
      check_sb();
      run = 1'b0;
      push("press_not_queued", 8'h03, 8'h00, 8'h05, 1'b0, 1'b0, 1'b0);
      step(4);
      check_sb();

      // 12h/24h display table
      do_reset();
      cur_hr = 0;
      for (int i = 0; i < 8; i++) begin
         press_n(1'b0, (vecs[i].hr - cur_hr + 24) % 24);
         cur_hr = vecs[i].hr;
         mode12 = vecs[i].m12;
         push($sformatf("disp_hr%0d_m%0b", vecs[i].hr, vecs[i].m12),
              8'h00, 8'h00, vecs[i].exp_hr, vecs[i].exp_pm, 1'b0, 1'b0);
         step(2);
         check_sb();
      end
      mode12 = 1'b0;
      push("both_press", 8'h00, 8'h01, 8'h21, 1'b0, 1'b0, 1'b0);
      press(1'b1, 1'b1);
      check_sb();
      push("hr_wrap", 8'h00, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0);
      press_n(1'b0, 3);
      check_sb();

      // reset in the middle of a second
      do_reset();
      press_n(1'b0, 10);
      press_n(1'b1, 20);
      run = 1'b1;
      push("pre_reset_102030", 8'h30, 8'h20, 8'h10, 1'b0, 1'b0, 1'b0);
      step(30 * 4 + 2);
      check_sb();
      push("mid_reset", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      do_reset();
      check_sb();
      push("no_tick_3", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      step(3);
      check_sb();
      push("tick_4", 8'h01, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
      step(1);
      check_sb();

`ifdef RTC_ALARM_EN
      run = 1'b0;
      do_reset();
      alm_sel = 1'b1;
      push("alm_edit_time_kept", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      press(1'b1, 1'b0);
      check_sb();
      alm_sel = 1'b0;
      run = 1'b1;
      push("alm_000058", 8'h58, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
      step(58 * 4);
      check_sb();
      push("alm_000059", 8'h59, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
      step(4);
      check_sb();
      push("alm_rise", 8'h00, 8'h01, 8'h00, 1'b0, 1'b1, 1'b1);
      step(4);
      check_sb();
      push("alm_hold", 8'h01, 8'h01, 8'h00, 1'b0, 1'b1, 1'b1);
      step(4);
      check_sb();
      push("alm_expire", 8'h02, 8'h01, 8'h00, 1'b0, 1'b1, 1'b0);
      step(4);
      check_sb();
      run = 1'b0;
      do_reset();
      alm_sel = 1'b1;
      press(1'b1, 1'b0);
      alm_sel = 1'b0;
      run = 1'b1;
      push("alm_rise2", 8'h00, 8'h01, 8'h00, 1'b0, 1'b1, 1'b1);
      step(60 * 4);
      check_sb();
      set_min_n = 1'b0;
      push("alm_press_clear", 8'h00, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0);
      step(3);
      check_sb();
      set_min_n = 1'b1;
      step(4);
`else
      run = 1'b0;
      do_reset();
      alm_sel = 1'b1;
      push("alm_sel_ignored", 8'h00, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0);
      press(1'b1, 1'b0);
      check_sb();
      alm_sel = 1'b0;
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
